// File: rtl/router_switch_alloc_if.sv
// router_switch_alloc_if: FIFO read sides (in_*) and downstream write sides (out_*) of the switch stage; ROUTER_SWITCH_STATS_EN adds stat_*_cnt
interface router_switch_alloc_if #(
  parameter int DATASIZE = 40
);
  logic [DATASIZE-1:0] in_L_data, in_N_data, in_E_data, in_S_data, in_W_data;
  logic in_L_valid, in_N_valid, in_E_valid, in_S_valid, in_W_valid;
  logic in_L_ready, in_N_ready, in_E_ready, in_S_ready, in_W_ready;
  logic [DATASIZE-1:0] out_L_data, out_N_data, out_E_data, out_S_data, out_W_data;
  logic out_L_valid, out_N_valid, out_E_valid, out_S_valid, out_W_valid;
  logic out_L_full, out_N_full, out_E_full, out_S_full, out_W_full;
`ifdef ROUTER_SWITCH_STATS_EN
  logic [15:0] stat_L_cnt, stat_N_cnt, stat_E_cnt, stat_S_cnt, stat_W_cnt;
`endif
  modport master (
    input in_L_data, in_N_data, in_E_data, in_S_data, in_W_data,
    input in_L_valid, in_N_valid, in_E_valid, in_S_valid, in_W_valid,
    input out_L_full, out_N_full, out_E_full, out_S_full, out_W_full,
`ifdef ROUTER_SWITCH_STATS_EN
    output stat_L_cnt, stat_N_cnt, stat_E_cnt, stat_S_cnt, stat_W_cnt,
`endif
    output in_L_ready, in_N_ready, in_E_ready, in_S_ready, in_W_ready,
    output out_L_data, out_N_data, out_E_data, out_S_data, out_W_data,
    output out_L_valid, out_N_valid, out_E_valid, out_S_valid, out_W_valid
  );
  modport slave (
    output in_L_data, in_N_data, in_E_data, in_S_data, in_W_data,
    output in_L_valid, in_N_valid, in_E_valid, in_S_valid, in_W_valid,
    output out_L_full, out_N_full, out_E_full, out_S_full, out_W_full,
`ifdef ROUTER_SWITCH_STATS_EN
    input stat_L_cnt, stat_N_cnt, stat_E_cnt, stat_S_cnt, stat_W_cnt,
`endif
    input in_L_ready, in_N_ready, in_E_ready, in_S_ready, in_W_ready,
    input out_L_data, out_N_data, out_E_data, out_S_data, out_W_data,
    input out_L_valid, out_N_valid, out_E_valid, out_S_valid, out_W_valid
  );
endinterface

// File: rtl/router_switch_alloc.sv
// router_switch_alloc: XY-routing round-robin switch stage with one-entry output slots; ROUTER_SWITCH_STATS_EN adds per-output transfer counters
module router_switch_alloc #(
  parameter int DATASIZE = 40,
  parameter int COORD_W = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input logic clk,
  input logic rst,
  router_switch_alloc_if.master bus
);
  localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);
  logic [4:0][DATASIZE-1:0] in_data, slot;
  logic [4:0] in_valid, in_ready, out_full, occ, free, busy;
  logic [4:0][2:0] route, rr, win;
  logic [4:0][4:0] req, gnt;
  logic [3:0] idx;
  function automatic logic [2:0] xy(input logic [DATASIZE-1:0] d);
    logic [COORD_W:0] dx, dy;
    dx = {1'b0, d[DATASIZE-1 -: COORD_W]} - {1'b0, LX};
    dy = {1'b0, d[DATASIZE-1-COORD_W -: COORD_W]} - {1'b0, LY};
    return dx[COORD_W] ? 3'd4 : |dx ? 3'd2 : dy[COORD_W] ? 3'd3 : |dy ? 3'd1 : 3'd0;
  endfunction
  assign in_data = {bus.in_W_data, bus.in_S_data, bus.in_E_data, bus.in_N_data, bus.in_L_data};
  assign in_valid = {bus.in_W_valid, bus.in_S_valid, bus.in_E_valid, bus.in_N_valid, bus.in_L_valid};
  assign out_full = {bus.out_W_full, bus.out_S_full, bus.out_E_full, bus.out_N_full, bus.out_L_full};
  assign {bus.in_W_ready, bus.in_S_ready, bus.in_E_ready, bus.in_N_ready, bus.in_L_ready} = in_ready;
  assign {bus.out_W_valid, bus.out_S_valid, bus.out_E_valid, bus.out_N_valid, bus.out_L_valid} = occ;
  assign bus.out_L_data = slot[0];
  assign bus.out_N_data = slot[1];
  assign bus.out_E_data = slot[2];
  assign bus.out_S_data = slot[3];
  assign bus.out_W_data = slot[4];
  assign busy = occ & ~out_full;
  // route every head flit and turn it into a request on its single output
  always_comb begin
    req = '0;
    route = '0;
    for (int i = 0; i < 5; i++) begin
      route[i] = xy(in_data[i]);
      req[route[i]][i] = in_valid[i];
    end
  end
  // round-robin from rr; scanning priorities in reverse lets the highest-priority hit overwrite the rest
  always_comb begin
    gnt = '0;
    win = '0;
    free = '0;
    idx = '0;
    for (int o = 0; o < 5; o++) begin
      free[o] = ~rst & (~occ[o] | ~out_full[o]);
      for (int k = 4; k >= 0; k--) begin
        idx = {1'b0, rr[o]} + 4'(k);
        idx = idx >= 4'd5 ? idx - 4'd5 : idx;
        if (free[o] && req[o][idx[2:0]]) begin
          gnt[o] = 5'(1) << idx;
          win[o] = idx[2:0];
        end
      end
    end
  end
  // an input is popped when its requested output granted it
  always_comb begin
    in_ready = '0;
    for (int o = 0; o < 5; o++) in_ready = in_ready | gnt[o];
  end
  // load granted flits (reload wins over drain), empty drained slots, move rr past each winner
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      slot <= '0;
      rr <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (|gnt[o]) begin
          occ[o] <= 1'b1;
          slot[o] <= in_data[win[o]];
          rr[o] <= win[o] == 3'd4 ? 3'd0 : win[o] + 3'd1;
        end else if (busy[o]) occ[o] <= 1'b0;
      end
    end
  end
`ifdef ROUTER_SWITCH_STATS_EN
  logic [4:0][15:0] cnt;
  // saturating count of flits accepted downstream on each output
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else for (int o = 0; o < 5; o++) if (busy[o] && !(&cnt[o])) cnt[o] <= cnt[o] + 16'd1;
  end
  assign bus.stat_L_cnt = cnt[0];
  assign bus.stat_N_cnt = cnt[1];
  assign bus.stat_E_cnt = cnt[2];
  assign bus.stat_S_cnt = cnt[3];
  assign bus.stat_W_cnt = cnt[4];
`endif
endmodule

// File: tb/tb_router_switch_alloc.sv
// tb_router_switch_alloc: directed plan cases plus randomized traffic against a queue-free behavioural router model
module tb_router_switch_alloc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] iv = '0;
  logic [4:0] fl = '0;
  logic [4:0][39:0] id = '0;
  logic [4:0] rdy, ov;
  logic [4:0][39:0] od;
  bit m_occ[5];
  logic [39:0] m_dat[5];
  int m_rr[5];
  int nchk = 0;
  int nfail = 0;
  router_switch_alloc_if #(.DATASIZE(40)) bus ();
  router_switch_alloc #(.DATASIZE(40), .COORD_W(4), .LOCAL_X(1), .LOCAL_Y(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.in_L_data = id[0];
  assign bus.in_N_data = id[1];
  assign bus.in_E_data = id[2];
  assign bus.in_S_data = id[3];
  assign bus.in_W_data = id[4];
  assign {bus.in_W_valid, bus.in_S_valid, bus.in_E_valid, bus.in_N_valid, bus.in_L_valid} = iv;
  assign {bus.out_W_full, bus.out_S_full, bus.out_E_full, bus.out_N_full, bus.out_L_full} = fl;
  assign rdy = {bus.in_W_ready, bus.in_S_ready, bus.in_E_ready, bus.in_N_ready, bus.in_L_ready};
  assign ov = {bus.out_W_valid, bus.out_S_valid, bus.out_E_valid, bus.out_N_valid, bus.out_L_valid};
  assign od = {bus.out_W_data, bus.out_S_data, bus.out_E_data, bus.out_N_data, bus.out_L_data};
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [39:0] pkt(input int x, input int y, input logic [31:0] p);
    return {4'(x), 4'(y), p};
  endfunction
  function automatic int dest(input logic [39:0] d);
    int x = int'(d[39:36]);
    int y = int'(d[35:32]);
    if (x > 1) return 2;
    if (x < 1) return 4;
    if (y > 1) return 1;
    if (y < 1) return 3;
    return 0;
  endfunction
  task automatic step(input logic r, input logic [4:0] v, input logic [4:0] f, input logic [4:0][39:0] d);
    logic [4:0] er;
    int g[5];
    @(negedge clk);
    for (int o = 0; o < 5; o++) begin
      check($sformatf("out_valid[%0d]", o), 40'(ov[o]), 40'(m_occ[o]));
      check($sformatf("out_data[%0d]", o), od[o], m_dat[o]);
    end
    rst = r;
    iv = v;
    fl = f;
    id = d;
    #1;
    er = '0;
    for (int o = 0; o < 5; o++) begin
      g[o] = -1;
      if (!r && (!m_occ[o] || !f[o])) begin
        for (int k = 0; k < 5; k++) begin
          int i = (m_rr[o] + k) % 5;
          if (v[i] && dest(d[i]) == o) begin
            g[o] = i;
            er[i] = 1'b1;
            break;
          end
        end
      end
    end
    check("in_ready", 40'(rdy), 40'(er));
    for (int o = 0; o < 5; o++) begin
      if (r) begin
        m_occ[o] = 0;
        m_dat[o] = '0;
        m_rr[o] = 0;
      end else if (g[o] >= 0) begin
        m_occ[o] = 1;
        m_dat[o] = d[g[o]];
        m_rr[o] = (g[o] + 1) % 5;
      end else if (m_occ[o] && !f[o]) m_occ[o] = 0;
    end
  endtask
  initial begin
    logic [4:0][39:0] d;
    logic [39:0] held;
    for (int o = 0; o < 5; o++) begin
      m_occ[o] = 0;
      m_dat[o] = '0;
      m_rr[o] = 0;
    end
    d = '0;
    step(1'b1, 5'h00, 5'h00, d);
    step(1'b0, 5'h00, 5'h00, d);
    check("reset_valid", 40'(ov), 40'h0);
    d[0] = pkt(3, 1, 32'hA5A5_0001);
    step(1'b0, 5'b00001, 5'h00, d);
    check("single_ready", 40'(rdy), 40'b00001);
    step(1'b0, 5'h00, 5'h00, d);
    check("single_valid", 40'(ov), 40'b00100);
    check("single_data", od[2], pkt(3, 1, 32'hA5A5_0001));
    d[0] = pkt(0, 1, 32'h1);
    d[1] = pkt(1, 2, 32'h2);
    d[2] = pkt(1, 0, 32'h3);
    d[3] = pkt(1, 1, 32'h4);
    d[4] = pkt(2, 2, 32'h5);
    step(1'b0, 5'h1f, 5'h00, d);
    check("map_ready", 40'(rdy), 40'h1f);
    step(1'b0, 5'h00, 5'h00, d);
    check("map_valid", 40'(ov), 40'h1f);
    check("map_W", od[4], d[0]);
    check("map_N", od[1], d[1]);
    check("map_S", od[3], d[2]);
    check("map_L", od[0], d[3]);
    check("map_E", od[2], d[4]);
    d[1] = pkt(2, 0, 32'h11);
    d[3] = pkt(3, 3, 32'h33);
    d[4] = pkt(2, 1, 32'h44);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 5'b11010, 5'h00, d);
      check("rr_order", 40'(rdy), c % 3 == 0 ? 40'b00010 : c % 3 == 1 ? 40'b01000 : 40'b10000);
    end
    held = d[4];
    d[0] = pkt(2, 1, 32'h77);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 5'b00001, 5'b00100, d);
      check("bp_ready", 40'(rdy), 40'h0);
      check("bp_valid", 40'(ov[2]), 40'h1);
      check("bp_data", od[2], held);
    end
    step(1'b0, 5'b00001, 5'h00, d);
    check("bp_release", 40'(rdy), 40'b00001);
    step(1'b0, 5'h00, 5'h00, d);
    check("bp_next", od[2], d[0]);
    d[0] = pkt(2, 1, 32'h88);
    d[1] = pkt(1, 3, 32'h99);
    step(1'b0, 5'b00011, 5'h00, d);
    step(1'b1, 5'h1f, 5'h00, d);
    check("rst_ready", 40'(rdy), 40'h0);
    for (int i = 0; i < 5; i++) d[i] = pkt(2, i, 32'hC0 + 32'(i));
    step(1'b0, 5'h1f, 5'h00, d);
    check("rst_valid", 40'(ov), 40'h0);
    check("rst_data", od[2], 40'h0);
    check("rst_rr", 40'(rdy), 40'b00001);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) d[i] = pkt($urandom_range(0, 3), $urandom_range(0, 3), $urandom());
      step($urandom_range(0, 99) == 0, 5'($urandom()), 5'($urandom() & $urandom()), d);
    end
    step(1'b0, 5'h00, 5'h00, d);
`ifdef ROUTER_SWITCH_STATS_EN
    step(1'b1, 5'h00, 5'h00, d);
    d[0] = pkt(3, 1, 32'hE);
    step(1'b0, 5'b00001, 5'h00, d);
    repeat (70000) @(negedge clk);
    iv = '0;
    repeat (3) @(negedge clk);
    check("stat_E", 40'(bus.stat_E_cnt), 40'hffff);
    check("stat_L", 40'(bus.stat_L_cnt), 40'h0);
    check("stat_N", 40'(bus.stat_N_cnt), 40'h0);
    check("stat_S", 40'(bus.stat_S_cnt), 40'h0);
    check("stat_W", 40'(bus.stat_W_cnt), 40'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
